match_reporter: RTL
===================

# match_reporter

Result-side back end for the parallel string-matching `system`. The matcher evaluates all `groups*num` weights (patterns) at one string position per step and pushes one hit vector per position. This block buffers those vectors in a small FIFO and serializes each set bit into a `(pattern id, position)` record on a valid/ready stream. It also counts reported matches and flags completion of the scan.

## Interface

**Parameters**
- `strlen`, 50: string length; positions run 0..`strlen`-1.
- `groups`, 4: number of matcher groups.
- `num`, 4: weights per group.
- `max_number_of_weight`, `num*groups`: width of the hit vector.
- `FIFO_DEPTH`, 8: input buffer entries; must be a power of two.
- Derived:
  - `PW = $clog2(strlen)`
  - `IW = $clog2(max_number_of_weight)`

**Ports**
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: a hit vector is offered.
- `in_ready` out 1: the block can accept a hit vector.
- `in_pos` in `PW`: string position of the hit vector.
- `in_hits` in `max_number_of_weight`: bit i set means weight i matched at `in_pos`.
- `in_last` in 1: marks the final position of the scan.
- `out_valid` out 1: a record is presented.
- `out_ready` in 1: the consumer accepts the record.
- `out_id` out `IW`: matching weight index.
- `out_pos` out `PW`: match position.
- `match_count` out 16: number of records delivered; saturates at 0xFFFF.
- `done` out 1: scan complete and all records delivered.

## Operation

- **Accept:** a hit vector is accepted on a cycle with `in_valid && in_ready`.
  - `in_hits` = 0: the entry is discarded, not stored. `in_last` is still honoured.
  - `in_hits` != 0: `{in_pos, in_hits}` is pushed into the FIFO.
  - `in_last` accepted: the `last_seen` flag is set.
- **Ready:** `in_ready = !fifo_full && !last_seen && !reset`.
  - The full check uses the pre-pop occupancy. A push and a pop in the same cycle are legal, but a full FIFO never accepts, even while popping.
- **Working register:** `{wpos, wvec}`.
- **FSM states:** IDLE and EMIT.
  - IDLE:
    - FIFO non-empty: pop the head into `{wpos, wvec}` and go to EMIT.
    - Otherwise stay in IDLE.
  - EMIT:
    - `out_valid` = 1.
    - `out_id` = index of the lowest set bit of `wvec`.
    - `out_pos` = `wpos`.
    - On `out_valid && out_ready`: clear that bit of `wvec` and increment `match_count` (saturating).
    - If the cleared `wvec` is zero and the FIFO is non-empty: pop the next entry in the same cycle and stay in EMIT. There is no bubble between entries.
    - If the cleared `wvec` is zero and the FIFO is empty: go to IDLE.
- **Ordering:** records leave in position order, and by ascending id within one position.
- **Done:** `done` = `last_seen && fifo_empty && state==IDLE`, registered. Once high it stays high until `reset`. No further input is accepted after `last_seen` until `reset`.

## Timing

- **Reset values:**
  - `out_valid` = 0, `out_id` = 0, `out_pos` = 0.
  - `match_count` = 0, `done` = 0.
  - `in_ready` = 0 while `reset` is high and 1 on the first cycle after `reset` falls.
  - FIFO empty, FSM in IDLE, `last_seen` = 0.
- **Latency:** an entry accepted at edge T into an empty FIFO with the FSM in IDLE gives `out_valid` high in the cycle after edge T+1. That is two edges from accept to the first record.
- **Throughput:** one record per cycle while `out_ready` = 1, including across entry boundaries.
- **Handshake:**
  - `out_id` and `out_pos` are stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a handshake, except on `reset`.
- **Capacity:** because the working register holds one entry, up to `FIFO_DEPTH+1` non-zero entries can be absorbed under full back-pressure.
- **`in_last` timing:**
  - Zero hits with an already empty pipeline: `done` rises two edges after the accepting edge.
  - Otherwise: `done` rises on the edge after the final record handshake.
- **Reset mid-operation:** at the next edge the FIFO, working register, flags and counter are cleared, and `out_valid` drops. No partial record is emitted.

## Test plan

1. **Single entry:** accept `in_pos`=5, `in_hits`=0x0012 with `out_ready`=1. Expect `out_valid` two edges later, then records (1,5) and (4,5) on consecutive cycles, then `match_count`=2 and `out_valid`=0.
2. **Zero-hit entries:** accept positions 0..3 with `in_hits`=0. Expect no `out_valid`, `match_count`=0, and `in_ready` staying 1.
3. **Back-pressure:** on entry (pos 7, hits 0x0100), hold `out_ready`=0 for 4 cycles. Expect `out_valid`=1 with (8,7) stable throughout, delivered on the first `out_ready`=1 cycle.
4. **FIFO full:** with `out_ready`=0, offer 12 entries of `in_hits`=0xFFFF. Expect exactly 9 accepted and `in_ready`=0 afterwards. Then set `out_ready`=1: expect 144 back-to-back records with no gaps, and `match_count`=144.
5. **Last entry:** accept `in_pos`=49, `in_hits`=0x8000, `in_last`=1. Expect record (15,49), then `done`=1 on the following edge. `in_ready` stays 0 and further `in_valid` is ignored.
6. **Reset mid-emission:** assert `reset` during test 4 draining. Expect on the next edge `out_valid`=0, `match_count`=0, `done`=0, FIFO empty, and normal operation once `reset` deasserts.

Source files
------------

// File: rtl/match_reporter.sv
// match_reporter: buffers per-position hit vectors and serializes each set bit
// into an (id, position) record on a valid/ready stream, with count and done.
module match_reporter #(
  parameter int strlen = 50,
  parameter int groups = 4,
  parameter int num = 4,
  parameter int max_number_of_weight = num * groups,
  parameter int FIFO_DEPTH = 8,
  localparam int PW = $clog2(strlen),
  localparam int IW = $clog2(max_number_of_weight)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [PW-1:0]                   in_pos,
  input  logic [max_number_of_weight-1:0] in_hits,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [IW-1:0]                   out_id,
  output logic [PW-1:0]                   out_pos,
  output logic [15:0]                     match_count,
  output logic                            done
);
  localparam int MW = max_number_of_weight;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = PW + MW;
  typedef enum logic {IDLE, EMIT} state_t;
  state_t r_state, w_next;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic [PW-1:0] r_wpos;
  logic [MW-1:0] r_wvec, w_cleared;
  logic [15:0] r_cnt;
  logic r_last, r_done;
  logic w_full, w_empty, w_acc, w_push, w_pop, w_hs, w_drained;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_full = (r_wr ^ r_rd) == {1'b1, {AW{1'b0}}};
  assign w_empty = r_wr == r_rd;
  assign in_ready = !w_full && !r_last && !reset;
  assign w_acc = in_valid && in_ready;
  assign w_push = w_acc && |in_hits;
  assign out_valid = r_state == EMIT;
  assign out_pos = r_wpos;
  assign match_count = r_cnt;
  assign done = r_done;
  assign w_hs = out_valid && out_ready;
  assign w_cleared = r_wvec & (r_wvec - MW'(1));
  assign w_drained = w_hs && w_cleared == '0;
  always_comb begin
    out_id = '0;
    for (int i = MW - 1; i >= 0; i--)
      if (r_wvec[i]) out_id = IW'(i);
  end
  always_comb begin
    w_pop = !w_empty && (r_state == IDLE || w_drained);
    w_next = (w_pop || (r_state == EMIT && !w_drained)) ? EMIT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wr <= '0;
      r_rd <= '0;
      r_wpos <= '0;
      r_wvec <= '0;
      r_cnt <= '0;
      r_last <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop) r_rd <= r_rd + (AW+1)'(1);
      if (w_pop) {r_wpos, r_wvec} <= r_mem[r_rd[AW-1:0]];
      else if (w_hs) r_wvec <= w_cleared;
      r_cnt <= (w_hs && r_cnt != 16'hFFFF) ? r_cnt + 16'd1 : r_cnt;
      r_last <= r_last || (w_acc && in_last);
      r_done <= r_done || (r_last && w_empty && r_state == IDLE);
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= {in_pos, in_hits};
endmodule
